// File: rtl/logic_sweep_pkg.sv
// Shared types and sizing for the logic sweep controller.
package logic_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    localparam int NUM_VEC = 8;
    localparam int IDX_W   = 3;
    localparam int CNT_W   = 4;

endpackage

// File: rtl/logic_golden.sv
// Reference behaviour of the 3-input combinational block under test.
module logic_golden (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic exp_x,
    output logic exp_y
);

    assign exp_x = ~(c ^ (a | b));
    // Written as in the lab handout; reduces to a & b.
    assign exp_y = (a | b) & (~(a & b) ^ (a | b));

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Steps a 3-input combinational unit through all 8 vectors, waits a settle
// time per vector, checks x/y against the golden model and reports results.
module logic_sweep_ctrl
    import logic_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter bit STOP_ON_FAIL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dut_x,
    input  logic             dut_y,
    output logic             vec_a,
    output logic             vec_b,
    output logic             vec_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [IDX_W-1:0] fail_vec
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VEC - 1);

    sweep_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [IDX_W-1:0] fail_q, fail_d;
    logic             first_q, first_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic exp_x, exp_y, mismatch;

    // The golden model sees the same registered vector the unit under test sees.
    logic_golden u_golden (
        .a     (idx_q[2]),
        .b     (idx_q[1]),
        .c     (idx_q[0]),
        .exp_x (exp_x),
        .exp_y (exp_y)
    );

    assign mismatch = (dut_x != exp_x) || (dut_y != exp_y);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        first_d = first_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SETTLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                    first_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + CNT_W'(1);
                    if (!first_q) begin
                        fail_d  = idx_q;
                        first_d = 1'b1;
                    end
                end
                if (idx_q == LAST_IDX || (STOP_ON_FAIL && mismatch)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_q == '0) && !mismatch;
                end else begin
                    state_d = SETTLE;
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_a     = idx_q[2];
    assign vec_b     = idx_q[1];
    assign vec_c     = idx_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule
